// File: rtl/sobel_result_streamer_pkg.sv
// Shared types and helpers for the Sobel result streamer.
// Latency: n/a (package). Backpressure: n/a.
// Holds one-hot FSM states, default frame size and the beat packing/saturation function.
package sobel_result_streamer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b100,
    STREAM = 3'b010,
    DONE   = 3'b001
  } state_t;

  localparam int NUM_WORDS_DEFAULT = 15876;

  // gx/gy arrive zero-extended; w is the RAM word width.
  function automatic logic [31:0] pack_beat(input logic [15:0] gx, input logic [15:0] gy,
                                            input int w);
`ifdef SOBEL_MAGNITUDE_OUT_EN
    logic [16:0] sum;
    logic [16:0] sat;
    sum = {1'b0, gx} + {1'b0, gy};
    sat = (17'd1 << w) - 17'd1;
    return (sum > sat) ? 32'(sat) : 32'(sum);
`else
    return (32'(gy) << w) | 32'(gx);
`endif
  endfunction

endpackage

// File: rtl/sobel_result_streamer_if.sv
// GX/GY RAM read ports, Start/Done handshake and AXI4-Stream master bundle.
// Latency: n/a (wiring). Backpressure: M_AXIS_TREADY from the slave side.
// master = streamer side, slave = RAMs/control/stream sink side.
interface sobel_result_streamer_if #(
  parameter int width         = 8,
  parameter int GX_depth_bits = 14,
  parameter int GY_depth_bits = 14,
  parameter int TDATA_WIDTH   = 32
);
  logic                     Start;
  logic                     Done;
  logic                     GX_read_en;
  logic [GX_depth_bits-1:0] GX_read_address;
  logic [width-1:0]         GX_read_data_out;
  logic                     GY_read_en;
  logic [GY_depth_bits-1:0] GY_read_address;
  logic [width-1:0]         GY_read_data_out;
  logic                     M_AXIS_TVALID;
  logic                     M_AXIS_TREADY;
  logic [TDATA_WIDTH-1:0]   M_AXIS_TDATA;
  logic                     M_AXIS_TLAST;

  modport master (
    input  Start, GX_read_data_out, GY_read_data_out, M_AXIS_TREADY,
    output Done, GX_read_en, GX_read_address, GY_read_en, GY_read_address,
           M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST
  );

  modport slave (
    output Start, GX_read_data_out, GY_read_data_out, M_AXIS_TREADY,
    input  Done, GX_read_en, GX_read_address, GY_read_en, GY_read_address,
           M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST
  );
endinterface

// File: rtl/sobel_result_streamer_fifo.sv
// Generic 2-entry FIFO used as the output skid buffer.
// Latency: write visible at head the cycle after push. Backpressure: caller must not push when full without popping.
// Head is combinational from storage; storage resets to zero so the head reads 0 out of reset.
module sobel_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign count   = cnt;
  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'd2);

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/sobel_result_streamer.sv
// Streams GX/GY RAM contents as AXI4-Stream beats, TLAST on the final word; SOBEL_MAGNITUDE_OUT_EN selects saturated GX+GY payload.
// Latency: first handshake 3 edges after Start is sampled in IDLE, then one beat per cycle.
// Backpressure: reads are throttled so the 2-entry skid FIFO never overflows; TVALID/TDATA/TLAST hold while TREADY is low.
module sobel_result_streamer
  import sobel_result_streamer_pkg::*;
#(
  parameter int width         = 8,
  parameter int GX_depth_bits = 14,
  parameter int GY_depth_bits = 14,
  parameter int NUM_WORDS     = NUM_WORDS_DEFAULT,
  parameter int TDATA_WIDTH   = 32
) (
  input logic                     clk,
  input logic                     resetn,
  sobel_result_streamer_if.master bus
);
  // One bit wider than the address so NUM_WORDS == 2^GX_depth_bits does not wrap.
  localparam int CW = GX_depth_bits + 1;
  localparam int FW = TDATA_WIDTH + 1;

  state_t        state;
  logic [CW-1:0] issued;
  logic          inflight;
  logic          inflight_last;
  logic          done_q;
  logic          rd_en;
  logic          pop;
  logic [1:0]    fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic [FW-1:0] push_dat;
  logic [FW-1:0] head;
  logic [2:0]    occ_next;

  // Occupancy after this edge counting the read already in flight.
  assign pop      = !fifo_empty && bus.M_AXIS_TREADY;
  assign occ_next = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en    = (state == STREAM) && (issued < CW'(NUM_WORDS)) && (occ_next < 3'd2);

  assign push_dat = {TDATA_WIDTH'(pack_beat(16'(bus.GX_read_data_out),
                                            16'(bus.GY_read_data_out), width)),
                     inflight_last};

  sobel_skid_fifo #(.W(FW)) u_fifo (
    .clk      (clk),
    .rst_n    (resetn),
    .push     (inflight),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en && (issued == CW'(NUM_WORDS - 1));
      if (rd_en) begin
        issued <= issued + CW'(1);
      end
      case (state)
        IDLE: begin
          issued <= '0;
          if (bus.Start) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (pop && head[0]) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.Start) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Done            = done_q;
  assign bus.GX_read_en      = rd_en;
  assign bus.GY_read_en      = rd_en;
  assign bus.GX_read_address = GX_depth_bits'(issued);
  assign bus.GY_read_address = GY_depth_bits'(issued);
  assign bus.M_AXIS_TVALID   = !fifo_empty;
  assign bus.M_AXIS_TDATA    = head[FW-1:1];
  assign bus.M_AXIS_TLAST    = head[0];

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
                                  !(inflight && fifo_full && !pop));

endmodule

// File: tb/tb_sobel_result_streamer.sv
// Directed bench: small 4-word instance for function/backpressure/reset, full-size instance for frame timing.
module tb_sobel_result_streamer;
  localparam int N  = 4;
  localparam int NF = 15876;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sobel_result_streamer_if #(.width(8), .GX_depth_bits(14), .GY_depth_bits(14), .TDATA_WIDTH(32)) bus ();
  sobel_result_streamer_if #(.width(8), .GX_depth_bits(14), .GY_depth_bits(14), .TDATA_WIDTH(32)) busf ();

  sobel_result_streamer #(.width(8), .GX_depth_bits(14), .GY_depth_bits(14),
                          .NUM_WORDS(N), .TDATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.master));

  sobel_result_streamer #(.width(8), .GX_depth_bits(14), .GY_depth_bits(14),
                          .NUM_WORDS(NF), .TDATA_WIDTH(32)) dut_f (
    .clk(clk), .resetn(resetn), .bus(busf.master));

  logic [7:0] gx_mem [N];
  logic [7:0] gy_mem [N];

  // Synchronous RAM models, one cycle read latency.
  always @(posedge clk) begin
    if (bus.GX_read_en) begin
      bus.GX_read_data_out <= gx_mem[bus.GX_read_address[1:0]];
      bus.GY_read_data_out <= gy_mem[bus.GY_read_address[1:0]];
    end
    if (busf.GX_read_en) begin
      busf.GX_read_data_out <= 8'(busf.GX_read_address + 14'd1);
      busf.GY_read_data_out <= 8'(busf.GY_read_address << 4);
    end
  end

  function automatic logic [31:0] exp_beat(input logic [7:0] gx, input logic [7:0] gy);
`ifdef SOBEL_MAGNITUDE_OUT_EN
    int s;
    s = int'(gx) + int'(gy);
    return (s > 255) ? 32'd255 : 32'(s);
`else
    return {16'd0, gy, gx};
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: TREADY=1, 1: toggle 1-0, 2: random ~30% low. Iteration c sits after edge c-1.
  task automatic run_frame(input int mode, input int drop_at, input bit check_timing);
    int beat, issued, first_hs, last_hs, done_c;
    bit stall_prev, got_done, rdy;
    logic [32:0] prev;
    beat = 0; issued = 0; first_hs = -1; last_hs = -1; done_c = -1;
    stall_prev = 1'b0; got_done = 1'b0; prev = '0;
    @(negedge clk);
    bus.Start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (c == drop_at) bus.Start = 1'b0;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : ($urandom_range(99) >= 30);
      bus.M_AXIS_TREADY = rdy;
      #1;
      if (bus.Done) begin
        got_done = 1'b1;
        done_c = c;
        break;
      end
      if (stall_prev) begin
        check("hold_vld", 64'(bus.M_AXIS_TVALID), 64'd1);
        check("hold_dat", 64'({bus.M_AXIS_TLAST, bus.M_AXIS_TDATA}), 64'(prev));
      end
      check("gy_mirror", 64'({bus.GY_read_en, bus.GY_read_address}),
            64'({bus.GX_read_en, bus.GX_read_address}));
      if (bus.GX_read_en) begin
        check("rd_addr", 64'(bus.GX_read_address), 64'(issued));
        issued++;
      end
      if (bus.M_AXIS_TVALID && rdy) begin
        check("tdata", 64'(bus.M_AXIS_TDATA), 64'(exp_beat(gx_mem[beat % N], gy_mem[beat % N])));
        check("tlast", 64'(bus.M_AXIS_TLAST), 64'(beat == N - 1));
        if (first_hs < 0) first_hs = c;
        last_hs = c;
        beat++;
      end
      check("occupancy", 64'(issued - beat <= 2), 64'd1);
      stall_prev = bus.M_AXIS_TVALID && !rdy;
      prev = {bus.M_AXIS_TLAST, bus.M_AXIS_TDATA};
      @(negedge clk);
    end
    check("done_seen", 64'(got_done), 64'd1);
    check("beats", 64'(beat), 64'(N));
    check("reads", 64'(issued), 64'(N));
    if (check_timing) begin
      check("first_hs_cyc", 64'(first_hs), 64'd3);
      check("last_hs_cyc", 64'(last_hs), 64'(N + 2));
      check("done_cyc", 64'(done_c), 64'(N + 3));
    end
    if (bus.Start) begin
      @(negedge clk); #1;
      check("done_hold", 64'(bus.Done), 64'd1);
      bus.Start = 1'b0;
      #1;
      check("done_reg", 64'(bus.Done), 64'd1);
    end
    @(negedge clk); #1;
    check("done_clear", 64'(bus.Done), 64'd0);
  endtask

  initial begin
    int hs, tl, last_hs, done_c, last_addr, errs;
    bus.Start = 1'b0;  bus.M_AXIS_TREADY = 1'b0;
    busf.Start = 1'b0; busf.M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < N; i++) begin
      gx_mem[i] = 8'(i + 1);
      gy_mem[i] = 8'(16 * i);
    end

    // Reset state
    #12;
    check("rst_tvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
    check("rst_tdata", 64'(bus.M_AXIS_TDATA), 64'd0);
    check("rst_tlast", 64'(bus.M_AXIS_TLAST), 64'd0);
    check("rst_rd_en", 64'(bus.GX_read_en), 64'd0);
    check("rst_addr", 64'(bus.GX_read_address), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Basic frame, full throughput
    run_frame(0, -1, 1);
    // Backpressure patterns
    run_frame(1, -1, 0);
    run_frame(2, -1, 0);
    run_frame(2, -1, 0);
    // Start dropped mid-stream
    run_frame(0, 2, 1);

    // Async reset mid-frame with FIFO holding data
    @(negedge clk);
    bus.Start = 1'b1;
    bus.M_AXIS_TREADY = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("pre_rst_tvalid", 64'(bus.M_AXIS_TVALID), 64'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("arst_tvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
    check("arst_tdata", 64'(bus.M_AXIS_TDATA), 64'd0);
    check("arst_tlast", 64'(bus.M_AXIS_TLAST), 64'd0);
    check("arst_rd_en", 64'(bus.GX_read_en), 64'd0);
    check("arst_addr", 64'(bus.GX_read_address), 64'd0);
    check("arst_done", 64'(bus.Done), 64'd0);
    bus.Start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run_frame(0, -1, 1);

    // Saturation corner data
    gx_mem[0] = 8'hF0; gy_mem[0] = 8'h20;
    gx_mem[1] = 8'h10; gy_mem[1] = 8'h20;
    gx_mem[2] = 8'hFF; gy_mem[2] = 8'h01;
    gx_mem[3] = 8'h00; gy_mem[3] = 8'h00;
    run_frame(0, -1, 1);

    // Full-size frame
    hs = 0; tl = 0; last_hs = -1; done_c = -1; last_addr = -1; errs = 0;
    @(negedge clk);
    busf.Start = 1'b1;
    busf.M_AXIS_TREADY = 1'b1;
    for (int c = 0; c < NF + 50; c++) begin
      #1;
      if (busf.Done) begin
        done_c = c;
        break;
      end
      if (busf.GX_read_en) last_addr = int'(busf.GX_read_address);
      if (busf.M_AXIS_TVALID) begin
        if (busf.M_AXIS_TDATA !== exp_beat(8'(hs + 1), 8'(hs * 16))) errs++;
        if (busf.M_AXIS_TLAST) tl++;
        last_hs = c;
        hs++;
      end
      @(negedge clk);
    end
    check("full_beats", 64'(hs), 64'(NF));
    check("full_tlast_cnt", 64'(tl), 64'd1);
    check("full_last_hs_cyc", 64'(last_hs), 64'(NF + 2));
    check("full_done_cyc", 64'(done_c), 64'(NF + 3));
    check("full_last_addr", 64'(last_addr), 64'(NF - 1));
    check("full_data_errs", 64'(errs), 64'd0);
    busf.Start = 1'b0;
    @(negedge clk); #1;
    check("full_done_clear", 64'(busf.Done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
